// File: rtl/sobel_stream.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_stream
//  Purpose  : Streaming 3x3 Sobel edge detector on an RGB raster.
//             RGB is reduced to grey, passed through two line buffers and a
//             3x3 window, and |Gx|+|Gy| (saturated, border pixels forced to 0)
//             is emitted on all three output channels.
//             Optional build macro SOBEL_THRESHOLD_EN binarises the result
//             against THRESH (full scale when >= THRESH, else 0).
//  Revision : 1.0  initial release
// ============================================================================
module sobel_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int THRESH = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] red_i,
   input  logic [DATA_W-1:0] green_i,
   input  logic [DATA_W-1:0] blue_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] red_o,
   output logic [DATA_W-1:0] green_o,
   output logic [DATA_W-1:0] blue_o,
   output logic              valid_o,
   output logic              frame_done_o
);

   localparam int c_cw = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int c_rw = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int c_fw = $clog2(IMG_W + 2);

   localparam logic [c_cw-1:0]   c_col_last   = c_cw'(IMG_W - 1);
   localparam logic [c_rw-1:0]   c_row_last   = c_rw'(IMG_H - 1);
   localparam logic [c_fw-1:0]   c_fill_full  = c_fw'(IMG_W + 1);
   localparam logic [c_fw-1:0]   c_flush_last = c_fw'(IMG_W);
   localparam logic [DATA_W-1:0] c_pix_max    = '1;

   localparam logic [0:0] c_st_run   = 1'b0;
   localparam logic [0:0] c_st_flush = 1'b1;

   // control
   logic [0:0]      r_state;
   logic [c_cw-1:0] r_col;
   logic [c_rw-1:0] r_row;
   logic [c_fw-1:0] r_flush_cnt;
   logic [c_fw-1:0] r_fill;
   logic [c_cw-1:0] r_lb_ptr;
   logic [c_cw-1:0] r_ocol;
   logic [c_rw-1:0] r_orow;

   logic w_accept;
   logic w_flush_tick;
   logic w_adv;
   logic w_emit;

   // data path
   logic [DATA_W+1:0] w_grey_sum;
   logic [DATA_W-1:0] w_grey;
   logic [DATA_W-1:0] w_sample;
   logic [DATA_W-1:0] w_lb1_q;
   logic [DATA_W-1:0] w_lb2_q;
   logic [DATA_W-1:0] r_lb1 [IMG_W];
   logic [DATA_W-1:0] r_lb2 [IMG_W];
   logic [DATA_W-1:0] r_win [3][3];

   logic signed [DATA_W+3:0] w_gx;
   logic signed [DATA_W+3:0] w_gy;
   logic [DATA_W+3:0]        w_gx_abs;
   logic [DATA_W+3:0]        w_gy_abs;
   logic [DATA_W+3:0]        r_gx_abs;
   logic [DATA_W+3:0]        r_gy_abs;
   logic [DATA_W+3:0]        w_sum;
   logic [DATA_W-1:0]        w_mag_sat;
   logic [DATA_W-1:0]        w_mag_final;
   logic [DATA_W-1:0]        r_mag;

   // pipeline qualifiers: valid, border, last-pixel
   logic r_v0, r_v1, r_v2;
   logic r_bord0, r_bord1, r_bord2;
   logic r_last0, r_last1, r_last2;

   // zero-extend a pixel into the signed gradient width
   function automatic logic signed [DATA_W+3:0] ext(input logic [DATA_W-1:0] p);
      return $signed({4'b0000, p});
   endfunction

   assign ready_o      = (r_state == c_st_run);
   assign w_accept     = ready_o & valid_i;
   assign w_flush_tick = (r_state == c_st_flush);
   assign w_adv        = w_accept | w_flush_tick;
   // the window centre is a real pixel once IMG_W+1 samples have entered
   assign w_emit       = w_adv & (r_fill == c_fill_full);

   assign w_grey_sum = {2'b00, red_i} + {1'b0, green_i, 1'b0} + {2'b00, blue_i};
   assign w_grey     = DATA_W'(w_grey_sum >> 2);
   // flush ticks push zeros; those only ever land in masked border positions
   assign w_sample   = ready_o ? w_grey : '0;

   assign w_lb1_q = r_lb1[r_lb_ptr];
   assign w_lb2_q = r_lb2[r_lb_ptr];

   // RUN/FLUSH state machine with input raster position
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_st_run;
         r_col       <= '0;
         r_row       <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_accept) begin
            if (r_col == c_col_last) begin
               r_col <= '0;
               if (r_row == c_row_last) begin
                  r_row       <= '0;
                  r_state     <= c_st_flush;
                  r_flush_cnt <= '0;
               end else begin
                  r_row <= r_row + 1'b1;
               end
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_flush_tick) begin
            if (r_flush_cnt == c_flush_last) begin
               r_state     <= c_st_run;
               r_flush_cnt <= '0;
            end else begin
               r_flush_cnt <= r_flush_cnt + 1'b1;
            end
         end
      end
   end

   // window fill tracking, line-buffer pointer and output raster position
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill   <= '0;
         r_lb_ptr <= '0;
         r_ocol   <= '0;
         r_orow   <= '0;
      end else begin
         if (w_flush_tick && (r_flush_cnt == c_flush_last)) begin
            r_fill <= '0;
         end else if (w_adv && (r_fill != c_fill_full)) begin
            r_fill <= r_fill + 1'b1;
         end
         if (w_adv) begin
            r_lb_ptr <= (r_lb_ptr == c_col_last) ? '0 : r_lb_ptr + 1'b1;
         end
         if (w_emit) begin
            if (r_ocol == c_col_last) begin
               r_ocol <= '0;
               r_orow <= (r_orow == c_row_last) ? '0 : r_orow + 1'b1;
            end else begin
               r_ocol <= r_ocol + 1'b1;
            end
         end
      end
   end

   // line buffers delay by one and two lines; window shifts left by one column
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_lb1[r_lb_ptr] <= w_sample;
         r_lb2[r_lb_ptr] <= w_lb1_q;
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= r_win[r][2];
         end
         r_win[0][2] <= w_lb2_q;
         r_win[1][2] <= w_lb1_q;
         r_win[2][2] <= w_sample;
      end
   end

   assign w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
               - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
   assign w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
               - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));

   assign w_gx_abs = w_gx[DATA_W+3] ? -w_gx : w_gx;
   assign w_gy_abs = w_gy[DATA_W+3] ? -w_gy : w_gy;

   assign w_sum     = r_gx_abs + r_gy_abs;
   assign w_mag_sat = (w_sum > {4'b0000, c_pix_max}) ? c_pix_max : w_sum[DATA_W-1:0];

`ifdef SOBEL_THRESHOLD_EN
   localparam logic [DATA_W+3:0] c_thresh = (DATA_W+4)'(THRESH);
   assign w_mag_final = ({4'b0000, w_mag_sat} >= c_thresh) ? c_pix_max : '0;
`else
   logic [31:0] w_unused_thresh;
   assign w_unused_thresh = 32'(THRESH);
   assign w_mag_final     = w_mag_sat;
`endif

   // pipeline qualifiers follow the data through the three stages
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v0    <= 1'b0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_bord0 <= 1'b0;
         r_bord1 <= 1'b0;
         r_bord2 <= 1'b0;
         r_last0 <= 1'b0;
         r_last1 <= 1'b0;
         r_last2 <= 1'b0;
      end else begin
         r_v0    <= w_emit;
         r_bord0 <= (r_ocol == '0) || (r_ocol == c_col_last) ||
                    (r_orow == '0) || (r_orow == c_row_last);
         r_last0 <= (r_ocol == c_col_last) && (r_orow == c_row_last);
         r_v1    <= r_v0;
         r_bord1 <= r_bord0;
         r_last1 <= r_last0;
         r_v2    <= r_v1;
         r_bord2 <= r_bord1;
         r_last2 <= r_last1;
      end
   end

   // gradient magnitudes, then saturated/thresholded magnitude
   always_ff @(posedge clk) begin
      r_gx_abs <= w_gx_abs;
      r_gy_abs <= w_gy_abs;
      r_mag    <= w_mag_final;
   end

   // output register with border masking
   always_ff @(posedge clk) begin
      if (rst) begin
         red_o        <= '0;
         green_o      <= '0;
         blue_o       <= '0;
         valid_o      <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         valid_o      <= r_v2;
         frame_done_o <= r_v2 & r_last2;
         if (r_v2) begin
            red_o   <= r_bord2 ? '0 : r_mag;
            green_o <= r_bord2 ? '0 : r_mag;
            blue_o  <= r_bord2 ? '0 : r_mag;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_stream
//  Purpose  : Self-checking bench for sobel_stream (4x4 frames). Expected
//             pixels come from a whole-frame Sobel model; a cycle-indexed
//             schedule gives when each result must appear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sobel_stream;

   localparam int DATA_W = 8;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;
   localparam int THRESH = 128;
   localparam int N      = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] red_i, green_i, blue_i;
   logic              valid_i;
   logic              ready_o;
   logic [DATA_W-1:0] red_o, green_o, blue_o;
   logic              valid_o;
   logic              frame_done_o;

   sobel_stream #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .THRESH (THRESH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .red_i        (red_i),
      .green_i      (green_i),
      .blue_i       (blue_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .red_o        (red_o),
      .green_o      (green_o),
      .blue_o       (blue_o),
      .valid_o      (valid_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // current frame and its expected output image
   int fr_r [N];
   int fr_g [N];
   int fr_b [N];
   int gr   [N];
   int exp_px [N];

   // results due at a given sampling cycle
   int sched_val  [int];
   int sched_last [int];

   int cyc = 0;
   int m_acc = 0;      // pixels accepted in current frame
   int m_flush = 0;    // flush ticks still to come
   int m_adv = 0;      // advances in current frame
   bit frame_end = 0;
   bit chk_zero = 0;

   function automatic int gpix(input int y, input int x);
      return gr[y*IMG_W + x];
   endfunction

   task automatic set_frame(input int kind, input int val);
      int c, gx, gy, mag;
      for (int i = 0; i < N; i++) begin
         case (kind)
            0: c = 100;
            1: c = ((i % IMG_W) >= 2) ? val : 0;
            default: c = -1;
         endcase
         if (c >= 0) begin
            fr_r[i] = c; fr_g[i] = c; fr_b[i] = c;
         end else begin
            fr_r[i] = $urandom_range(0, 255);
            fr_g[i] = $urandom_range(0, 255);
            fr_b[i] = $urandom_range(0, 255);
         end
         gr[i] = (fr_r[i] + 2*fr_g[i] + fr_b[i]) / 4;
      end
      for (int y = 0; y < IMG_H; y++) begin
         for (int x = 0; x < IMG_W; x++) begin
            if (y == 0 || y == IMG_H-1 || x == 0 || x == IMG_W-1) begin
               exp_px[y*IMG_W + x] = 0;
            end else begin
               gx = (gpix(y-1,x+1) + 2*gpix(y,x+1) + gpix(y+1,x+1))
                  - (gpix(y-1,x-1) + 2*gpix(y,x-1) + gpix(y+1,x-1));
               gy = (gpix(y+1,x-1) + 2*gpix(y+1,x) + gpix(y+1,x+1))
                  - (gpix(y-1,x-1) + 2*gpix(y-1,x) + gpix(y-1,x+1));
               mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
               if (mag > 255) mag = 255;
`ifdef SOBEL_THRESHOLD_EN
               mag = (mag >= THRESH) ? 255 : 0;
`endif
               exp_px[y*IMG_W + x] = mag;
            end
         end
      end
   endtask

   // one clock: check outputs at the falling edge, then drive the next inputs
   task automatic step(input bit v, input bit do_rst);
      bit exp_ready;
      bit adv;
      int j;
      @(negedge clk);
      cyc++;
      if (sched_val.exists(cyc)) begin
         check("valid_o", valid_o, 1);
         check("red_o", red_o, sched_val[cyc]);
         check("green_o", green_o, sched_val[cyc]);
         check("blue_o", blue_o, sched_val[cyc]);
         check("frame_done_o", frame_done_o, sched_last[cyc]);
         sched_val.delete(cyc);
         sched_last.delete(cyc);
      end else begin
         check("valid_o_idle", valid_o, 0);
         check("frame_done_idle", frame_done_o, 0);
      end
      if (chk_zero) begin
         check("rst_red_o", red_o, 0);
         check("rst_green_o", green_o, 0);
         check("rst_blue_o", blue_o, 0);
         chk_zero = 0;
      end
      exp_ready = (m_flush == 0);
      check("ready_o", ready_o, exp_ready);

      rst     = do_rst;
      valid_i = v;
      if (m_acc < N) begin
         red_i   = fr_r[m_acc][DATA_W-1:0];
         green_i = fr_g[m_acc][DATA_W-1:0];
         blue_i  = fr_b[m_acc][DATA_W-1:0];
      end else begin
         red_i   = DATA_W'($urandom_range(0, 255));
         green_i = DATA_W'($urandom_range(0, 255));
         blue_i  = DATA_W'($urandom_range(0, 255));
      end

      if (do_rst) begin
         m_acc = 0; m_flush = 0; m_adv = 0;
         sched_val.delete();
         sched_last.delete();
         chk_zero = 1;
      end else begin
         adv = (exp_ready && v) || (m_flush > 0);
         if (adv) begin
            if (m_adv >= IMG_W + 1) begin
               j = m_adv - (IMG_W + 1);
               sched_val[cyc + 4]  = exp_px[j];
               sched_last[cyc + 4] = (j == N-1) ? 1 : 0;
            end
            m_adv++;
            if (m_flush > 0) begin
               m_flush--;
               if (m_flush == 0) begin
                  m_adv = 0; m_acc = 0; frame_end = 1;
               end
            end else begin
               m_acc++;
               if (m_acc == N) m_flush = IMG_W + 1;
            end
         end
      end
   endtask

   // vmode: 0 continuous, 1 toggling 1-0-1-0, 2 random gaps
   task automatic run_frame(input int vmode);
      int guard;
      bit tog;
      bit v;
      guard = 0;
      tog = 1'b1;
      frame_end = 0;
      while (!frame_end && guard < 20*N) begin
         case (vmode)
            0: v = 1'b1;
            1: begin v = tog; tog = ~tog; end
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         step(v, 1'b0);
         guard++;
      end
      if (!frame_end) check("frame_timeout", 0, 1);
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0;
      red_i = '0; green_i = '0; blue_i = '0;
      for (int i = 0; i < N; i++) begin
         fr_r[i] = 0; fr_g[i] = 0; fr_b[i] = 0; gr[i] = 0; exp_px[i] = 0;
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      set_frame(0, 0);   run_frame(0);   // flat grey
      set_frame(1, 20);  run_frame(0);   // vertical edge
      set_frame(1, 200); run_frame(0);   // saturating edge
      set_frame(1, 20);  run_frame(1);   // same edge, stalled input
      set_frame(2, 0);   run_frame(2);
      set_frame(2, 0);   run_frame(0);

      // abort a frame after 7 accepts, then a clean edge frame
      set_frame(2, 0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      set_frame(1, 20);  run_frame(0);

      set_frame(2, 0);   run_frame(1);
      repeat (8) step(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
